// File: rtl/rom_fetch_sequencer_if.sv
// Instruction issue channel between the fetch sequencer and the datapath.
// The sequencer drives the decoded word; the datapath answers with ready.
interface rom_fetch_sequencer_if;
    logic       instr_valid;
    logic       instr_ready;
    logic [7:0] instr;
    logic [1:0] op_class;
    logic [5:0] imm;
    logic [2:0] src_sel;
    logic [2:0] dst_sel;

    modport master (
        output instr_valid,
        output instr,
        output op_class,
        output imm,
        output src_sel,
        output dst_sel,
        input  instr_ready
    );

    modport slave (
        input  instr_valid,
        input  instr,
        input  op_class,
        input  imm,
        input  src_sel,
        input  dst_sel,
        output instr_ready
    );
endinterface

// File: rtl/rom_fetch_sequencer.sv
// PC/fetch/issue sequencer for the 8-bit program ROM.
// Resolves COND jumps at the handshake and parks on jump-to-self.
module rom_fetch_sequencer #(
    parameter logic [7:0] RESET_PC = 8'h00,
    parameter int         CNT_W    = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 run,
    output logic [7:0]           rom_address,
    input  logic [7:0]           rom_data,
    rom_fetch_sequencer_if.master bus,
    input  logic [7:0]           jump_target,
    input  logic [7:0]           cond_operand,
    output logic [7:0]           pc,
    output logic                 halted,
    output logic [CNT_W-1:0]     retired
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        ISSUE = 2'd2,
        HALT  = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [7:0]       pc_q;
    logic [7:0]       instr_q;
    logic             halted_q;
    logic [CNT_W-1:0] retired_q;

    logic hs;
    logic is_cond;
    logic cond_true;
    logic taken;
    logic self_jump;
    logic op_zero;
    logic op_neg;

    assign hs        = (state == ISSUE) && bus.instr_ready;
    assign is_cond   = (instr_q[7:6] == 2'b11);
    assign op_zero   = (cond_operand == 8'h00);
    assign op_neg    = cond_operand[7];
    assign taken     = is_cond && cond_true;
    assign self_jump = taken && (jump_target == pc_q);

    always_comb begin
        cond_true = 1'b0;
        unique case (instr_q[2:0])
            3'b000: cond_true = 1'b0;
            3'b001: cond_true = op_zero;
            3'b010: cond_true = op_neg;
            3'b011: cond_true = op_neg || op_zero;
            3'b100: cond_true = 1'b1;
            3'b101: cond_true = !op_zero;
            3'b110: cond_true = !op_neg;
            3'b111: cond_true = !op_neg && !op_zero;
            default: cond_true = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:  if (run) state_nx = FETCH;
            FETCH: state_nx = ISSUE;
            ISSUE: begin
                if (hs) begin
                    if (self_jump) state_nx = HALT;
                    else if (run)  state_nx = FETCH;
                    else           state_nx = IDLE;
                end
            end
            HALT:  state_nx = HALT;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        bus.instr_valid = (state == ISSUE);
    end

    // PC, latched word and counters only move on FETCH or a handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q      <= RESET_PC;
            instr_q   <= 8'h00;
            halted_q  <= 1'b0;
            retired_q <= '0;
        end else begin
            if (state == FETCH) instr_q <= rom_data;
            if (hs) begin
                retired_q <= retired_q + CNT_W'(1);
                pc_q      <= taken ? jump_target : pc_q + 8'd1;
                if (self_jump) halted_q <= 1'b1;
            end
        end
    end

    assign rom_address  = pc_q;
    assign pc           = pc_q;
    assign halted       = halted_q;
    assign retired      = retired_q;
    assign bus.instr    = instr_q;
    assign bus.op_class = instr_q[7:6];
    assign bus.imm      = instr_q[5:0];
    assign bus.src_sel  = instr_q[5:3];
    assign bus.dst_sel  = instr_q[2:0];

endmodule

// File: tb/tb_rom_fetch_sequencer.sv
// Bench for rom_fetch_sequencer: ROM array plus an architectural model
// that tracks PC, retired count and halt per accepted instruction.
module tb_rom_fetch_sequencer;

    logic        clk;
    logic        rst_n;
    logic        run;
    logic [7:0]  rom_address;
    logic [7:0]  rom_data;
    logic [7:0]  jump_target;
    logic [7:0]  cond_operand;
    logic [7:0]  pc;
    logic        halted;
    logic [15:0] retired;

    logic [7:0]  rom [256];

    rom_fetch_sequencer_if bus ();

    rom_fetch_sequencer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .run          (run),
        .rom_address  (rom_address),
        .rom_data     (rom_data),
        .bus          (bus),
        .jump_target  (jump_target),
        .cond_operand (cond_operand),
        .pc           (pc),
        .halted       (halted),
        .retired      (retired)
    );

    assign rom_data = rom[rom_address];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]  m_pc;
    logic [15:0] m_ret;
    bit          m_halt;

    function automatic bit cond_taken(input logic [2:0] c, input logic [7:0] op);
        int v;
        v = int'($signed(op));
        case (c)
            3'd0: return 1'b0;
            3'd1: return v == 0;
            3'd2: return v < 0;
            3'd3: return v <= 0;
            3'd4: return 1'b1;
            3'd5: return v != 0;
            3'd6: return v >= 0;
            default: return v > 0;
        endcase
    endfunction

    function automatic void model_step(input logic [7:0] w);
        if (w[7:6] == 2'b11 && cond_taken(w[2:0], cond_operand)) begin
            if (jump_target == m_pc) m_halt = 1'b1;
            m_pc = jump_target;
        end else begin
            m_pc = m_pc + 8'd1;
        end
        m_ret = m_ret + 16'd1;
    endfunction

    task automatic fill_rom(input logic [7:0] v);
        for (int i = 0; i < 256; i++) rom[i] = v;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        run = 1'b0;
        bus.instr_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        m_pc = 8'h00;
        m_ret = 16'd0;
        m_halt = 1'b0;
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.instr_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic accept();
        bus.instr_ready = 1'b1;
        model_step(rom[m_pc]);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        fill_rom(8'h01);
        jump_target = 8'h00;
        cond_operand = 8'h00;
        rst_n = 1'b0;
        run = 1'b1;
        bus.instr_ready = 1'b1;
        #1;
        n_checks++;
        if (bus.instr_valid !== 1'b0 || pc !== 8'h00 || rom_address !== 8'h00 ||
            bus.instr !== 8'h00 || halted !== 1'b0 || retired !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_state: valid=%b pc=%h addr=%h instr=%h halted=%b retired=%0d want 0/00/00/00/0/0",
                     bus.instr_valid, pc, rom_address, bus.instr, halted, retired);
        end
        do_reset();
    endtask

    task automatic test_counting();
        bit ok;
        for (int i = 0; i < 10; i++) begin
            rom[2*i]   = 8'h30 + 8'(i);
            rom[2*i+1] = 8'h86;
        end
        rom[20] = 8'h00;
        rom[21] = 8'hC4;
        jump_target = 8'h00;
        cond_operand = 8'h00;
        do_reset();
        bus.instr_ready = 1'b1;
        run = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.instr_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL first_latency_early: valid=%b want 0", bus.instr_valid);
        end
        @(negedge clk);
        n_checks++;
        if (bus.instr_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL first_latency: valid=%b want 1", bus.instr_valid);
        end
        for (int k = 0; k < 44; k++) begin
            wait_valid(ok);
            n_checks++;
            if (!ok || bus.instr !== rom[m_pc] || pc !== m_pc) begin
                n_fail++;
                $display("FAIL count_issue[%0d]: ok=%b instr=%h pc=%h want %h/%h",
                         k, ok, bus.instr, pc, rom[m_pc], m_pc);
            end
            accept();
            if (k == 21) begin
                n_checks++;
                if (pc !== 8'h00 || retired !== 16'd22) begin
                    n_fail++;
                    $display("FAIL count_loop: pc=%h retired=%0d want 00/22", pc, retired);
                end
            end
        end
        n_checks++;
        if (retired !== 16'd44 || halted !== 1'b0 || pc !== m_pc) begin
            n_fail++;
            $display("FAIL count_end: retired=%0d halted=%b pc=%h want 44/0/%h",
                     retired, halted, pc, m_pc);
        end
    endtask

    task automatic test_halt();
        bit ok;
        fill_rom(8'h01);
        rom[5] = 8'hC4;
        jump_target = 8'h05;
        cond_operand = 8'h00;
        do_reset();
        run = 1'b1;
        for (int k = 0; k < 6; k++) begin
            wait_valid(ok);
            n_checks++;
            if (!ok) begin
                n_fail++;
                $display("FAIL halt_wait[%0d]: valid never rose", k);
            end
            accept();
        end
        n_checks++;
        if (halted !== 1'b1 || pc !== 8'h05 || m_halt !== 1'b1) begin
            n_fail++;
            $display("FAIL halt_state: halted=%b pc=%h want 1/05", halted, pc);
        end
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            n_checks++;
            if (bus.instr_valid !== 1'b0 || pc !== 8'h05 || retired !== 16'd6) begin
                n_fail++;
                $display("FAIL halt_hold[%0d]: valid=%b pc=%h retired=%0d want 0/05/6",
                         k, bus.instr_valid, pc, retired);
            end
        end
    endtask

    task automatic test_cond_codes();
        bit ok;
        logic [7:0] ops [3];
        logic [7:0] want;
        ops[0] = 8'h00;
        ops[1] = 8'h80;
        ops[2] = 8'h7F;
        for (int c = 0; c < 8; c++) begin
            for (int o = 0; o < 3; o++) begin
                fill_rom(8'h01);
                rom[0] = {2'b11, 3'b000, 3'(c)};
                jump_target = 8'h40;
                cond_operand = ops[o];
                do_reset();
                run = 1'b1;
                wait_valid(ok);
                want = cond_taken(3'(c), ops[o]) ? 8'h40 : 8'h01;
                accept();
                n_checks++;
                if (!ok || pc !== want || rom_address !== want) begin
                    n_fail++;
                    $display("FAIL cond_%0d_op%h: ok=%b pc=%h want %h", c, ops[o], ok, pc, want);
                end
            end
        end
    endtask

    task automatic test_stall();
        bit ok;
        fill_rom(8'h01);
        rom[0] = 8'h9A;
        do_reset();
        run = 1'b1;
        wait_valid(ok);
        for (int k = 0; k < 5; k++) begin
            n_checks++;
            if (!ok || bus.instr_valid !== 1'b1 || bus.instr !== 8'h9A ||
                bus.op_class !== 2'b10 || bus.imm !== 6'h1A || bus.src_sel !== 3'd3 ||
                bus.dst_sel !== 3'd2 || retired !== 16'd0) begin
                n_fail++;
                $display("FAIL stall[%0d]: v=%b instr=%h cls=%b imm=%h src=%0d dst=%0d ret=%0d want 1/9a/10/1a/3/2/0",
                         k, bus.instr_valid, bus.instr, bus.op_class, bus.imm,
                         bus.src_sel, bus.dst_sel, retired);
            end
            @(negedge clk);
        end
        accept();
        n_checks++;
        if (retired !== 16'd1 || pc !== 8'h01) begin
            n_fail++;
            $display("FAIL stall_release: retired=%0d pc=%h want 1/01", retired, pc);
        end
    endtask

    task automatic test_wrap();
        bit ok;
        fill_rom(8'h01);
        rom[0] = 8'hC4;
        rom[8'hFF] = 8'h15;
        jump_target = 8'hFF;
        cond_operand = 8'h00;
        do_reset();
        run = 1'b1;
        wait_valid(ok);
        accept();
        wait_valid(ok);
        n_checks++;
        if (!ok || pc !== 8'hFF || bus.instr !== 8'h15) begin
            n_fail++;
            $display("FAIL wrap_at_ff: ok=%b pc=%h instr=%h want ff/15", ok, pc, bus.instr);
        end
        accept();
        n_checks++;
        if (rom_address !== 8'h00 || pc !== 8'h00) begin
            n_fail++;
            $display("FAIL wrap_to_00: addr=%h pc=%h want 00", rom_address, pc);
        end
    endtask

    task automatic test_run_stop();
        bit ok;
        fill_rom(8'h01);
        rom[1] = 8'h82;
        do_reset();
        run = 1'b1;
        wait_valid(ok);
        run = 1'b0;
        bus.instr_ready = 1'b0;
        @(negedge clk);
        n_checks++;
        if (!ok || bus.instr_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL run_stop_hold: valid=%b want 1", bus.instr_valid);
        end
        accept();
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (bus.instr_valid !== 1'b0 || pc !== 8'h01) begin
                n_fail++;
                $display("FAIL run_stop_idle[%0d]: valid=%b pc=%h want 0/01", k, bus.instr_valid, pc);
            end
            @(negedge clk);
        end
        run = 1'b1;
        wait_valid(ok);
        n_checks++;
        if (!ok || bus.instr !== 8'h82) begin
            n_fail++;
            $display("FAIL run_resume: ok=%b instr=%h want 82", ok, bus.instr);
        end
    endtask

    task automatic test_async_reset();
        bit ok;
        fill_rom(8'h01);
        rom[0] = 8'h2C;
        do_reset();
        run = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wait_valid(ok);
            if (k < 2) accept();
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (!ok || bus.instr_valid !== 1'b0 || pc !== 8'h00 || bus.instr !== 8'h00 ||
            retired !== 16'd0 || halted !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: ok=%b valid=%b pc=%h instr=%h ret=%0d halted=%b want 0/00/00/0/0",
                     ok, bus.instr_valid, pc, bus.instr, retired, halted);
        end
        @(negedge clk);
        rst_n = 1'b1;
        m_pc = 8'h00;
        m_ret = 16'd0;
        m_halt = 1'b0;
        wait_valid(ok);
        n_checks++;
        if (!ok || pc !== 8'h00 || bus.instr !== 8'h2C) begin
            n_fail++;
            $display("FAIL async_refetch: ok=%b pc=%h instr=%h want 00/2c", ok, pc, bus.instr);
        end
    endtask

    task automatic test_random();
        logic v;
        logic [7:0] ops [4];
        ops[0] = 8'h00;
        ops[1] = 8'h80;
        ops[2] = 8'h7F;
        ops[3] = 8'h01;
        for (int i = 0; i < 256; i++) rom[i] = 8'($urandom);
        do_reset();
        run = 1'b1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            v = bus.instr_valid;
            n_checks++;
            if (pc !== m_pc || retired !== m_ret || halted !== m_halt ||
                (m_halt && v !== 1'b0) ||
                (v === 1'b1 && bus.instr !== rom[m_pc])) begin
                n_fail++;
                $display("FAIL random[%0d]: pc=%h ret=%0d halted=%b v=%b instr=%h want %h/%0d/%b/%h",
                         cyc, pc, retired, halted, v, bus.instr, m_pc, m_ret, m_halt, rom[m_pc]);
            end
            if (m_halt) begin
                for (int i = 0; i < 256; i++) rom[i] = 8'($urandom);
                do_reset();
                run = 1'b1;
            end else begin
                run = ($urandom_range(0, 7) != 0);
                bus.instr_ready = ($urandom_range(0, 3) != 0);
                jump_target = ($urandom_range(0, 5) == 0) ? m_pc : 8'($urandom);
                cond_operand = ($urandom_range(0, 1) == 0) ? ops[$urandom_range(0, 3)]
                                                           : 8'($urandom);
                if (v === 1'b1 && bus.instr_ready) model_step(rom[m_pc]);
                @(negedge clk);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        run = 1'b0;
        bus.instr_ready = 1'b0;
        jump_target = 8'h00;
        cond_operand = 8'h00;
        m_pc = 8'h00;
        m_ret = 16'd0;
        m_halt = 1'b0;
        @(negedge clk);
        test_reset();
        test_counting();
        test_halt();
        test_cond_codes();
        test_stall();
        test_wrap();
        test_run_stop();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
